imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Instruction-memory responder: the slave end of the core's instruction fetch interface (req/addr out, rvalid/rdata back).
- Holds a single-port word-organised SRAM array. Each accepted fetch returns one word after a fixed latency of 1+WAIT_STATES cycles.
- A secondary load port lets a boot loader or testbench write the program image, byte-enabled, while the core is halted.
- Sits between the core's fetch stage and the on-chip instruction RAM, inside the core top level.

Parameters:
- MEM_WORDS, 4096: array depth in 32-bit words; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to 4*MEM_WORDS.
- WAIT_STATES, 0: extra cycles added to the read latency; range 0..7.
- ERR_RDATA, 32'h0000_0013: data returned on an erroneous fetch (NOP).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch byte address
- instr_gnt_o  out  1  request accepted this cycle (combinational)
- instr_rvalid_o  out  1  response valid
- instr_rdata_o  out  32  response data
- instr_err_o  out  1  response is an error; qualified by rvalid
- load_we_i  in  1  load-port write request
- load_addr_i  in  32  load byte address
- load_be_i  in  4  byte enables
- load_wdata_i  in  32  write data
- load_ready_o  out  1  load write accepted this cycle (combinational)
- busy_o  out  1  a fetch is outstanding

Behaviour:
- Reset: rst_n is asynchronous, active low; clock is clk. Reset values:
  - FSM = IDLE, wait counter = 0.
  - instr_rvalid_o = 0, instr_err_o = 0, instr_rdata_o = 0, busy_o = 0.
  - The array contents are not reset.
  - Reset asserted mid-operation aborts the outstanding fetch; no rvalid is ever produced for it.
- Word index = (addr - BASE_ADDR) >> 2, width $clog2(MEM_WORDS). Range check uses a 33-bit subtract, so no wrap-around aliasing.
- Fetch error: addr[1:0] != 0, or addr outside [BASE_ADDR, BASE_ADDR + 4*MEM_WORDS). The response then has rdata = ERR_RDATA and err = 1. An errored fetch never reads the array.
- Grant rule: instr_gnt_o = instr_req_i & (state == IDLE | response completing this cycle).
  - With WAIT_STATES = 0 the grant is always equal to instr_req_i, so back-to-back fetches every cycle are supported.
- FSM states:
  - IDLE: on gnt, latch addr and error flag. If WAIT_STATES == 0, go to RESP; else go to WAIT with the counter loaded to WAIT_STATES-1.
  - WAIT: decrement the counter; when the counter is 0, go to RESP.
  - RESP: the array read is issued on entry so data is registered. Assert instr_rvalid_o for exactly 1 cycle.
    - If gnt occurs in the same cycle, follow the IDLE transition rules; otherwise return to IDLE.
- Latency: a request granted at cycle N gives rvalid high at cycle N+1+WAIT_STATES.
- Data hold: instr_rdata_o and instr_err_o hold their last response value while rvalid is low; instr_err_o is meaningful only with rvalid.
- Ungranted request: instr_req_i high while not granted is ignored; it is not queued.
- busy_o = (state != IDLE).
- Load port:
  - load_ready_o = load_we_i & ~(array read in this cycle). Fetch always wins the array port.
  - On load_ready_o, write only the enabled byte lanes at the load word index.
  - Writes with misaligned or out-of-range addresses are accepted and dropped.
  - A fetch of the same word in the cycle after a write returns the new data.
- No read-during-write collision is possible, since only one port access happens per cycle.

Test Plan:
- Loading (WAIT_STATES = 0): load 0xDEADBEEF at 0x0, 0x00000013 at 0x4, be = 4'hF. Then req at 0x0 in cycle N and 0x4 in cycle N+1 -> rvalid in N+1 and N+2 with rdata 0xDEADBEEF then 0x00000013, err = 0, gnt high both cycles.
- Wait states (WAIT_STATES = 2): req at 0x4 held high continuously -> gnt at N, rvalid at N+3; next gnt at N+3, next rvalid at N+6; gnt low during N+1..N+2.
- Errors: req at 0x2 -> rvalid 1 cycle later, rdata = 0x00000013, err = 1. Req at BASE_ADDR + 4*MEM_WORDS -> same. Req at BASE_ADDR-4 -> same.
- Byte enables: word 0x8 = 0x11223344, then write be = 4'b0101 with 0xAABBCCDD -> fetch of 0x8 returns 0x11BB33DD.
- Port conflict: load_we_i and a fetch granted in the same cycle -> load_ready_o = 0 that cycle and the write lands the next cycle; the fetch data is unaffected.
- Reset mid-fetch (WAIT_STATES = 3): assert rst_n low 1 cycle after gnt -> rvalid never asserts; busy_o = 0, rdata = 0; the next fetch after reset returns correct data.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory responder: serves core fetches from a word-organised SRAM
// after 1+WAIT_STATES cycles, with a byte-enabled load port for the program image.
module imem_responder #(
  parameter int unsigned MEM_WORDS   = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ERR_RDATA   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [3:0]  load_be_i,
  input  logic [31:0] load_wdata_i,
  output logic        load_ready_o,
  output logic        busy_o
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  typedef struct packed {
    logic             ok;
    logic [IDX_W-1:0] idx;
  } dec_t;

  // The 33-bit offset keeps addresses below BASE_ADDR from wrapping into range.
  function automatic dec_t decode(input logic [31:0] addr);
    logic [32:0] off;
    dec_t        d;
    off   = {1'b0, addr} - {1'b0, BASE_ADDR};
    d.idx = off[IDX_W+1:2];
    d.ok  = ~off[32] && ((off[31:0] >> (IDX_W + 2)) == 32'd0) && (addr[1:0] == 2'b00);
    return d;
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q;
  logic             err_q;
  logic [31:0]      hold_rdata_q;
  logic             hold_err_q;
  logic [31:0]      ram_q;
  logic [31:0]      mem [MEM_WORDS];

  dec_t             fetch_dec, load_dec;
  logic             gnt;
  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic             wr_en;

  assign fetch_dec = decode(instr_addr_i);
  assign load_dec  = decode(load_addr_i);

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    rd_en   = 1'b0;
    rd_idx  = idx_q;
    unique case (state_q)
      S_IDLE, S_RESP: begin
        gnt = instr_req_i;
        if (state_q == S_RESP) state_d = S_IDLE;
        if (instr_req_i) begin
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            rd_en   = fetch_dec.ok;
            rd_idx  = fetch_dec.idx;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 3'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = S_RESP;
          rd_en   = ~err_q;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign instr_gnt_o    = gnt;
  assign instr_rvalid_o = (state_q == S_RESP);
  assign busy_o         = (state_q != S_IDLE);
  assign load_ready_o   = load_we_i & ~rd_en;
  assign wr_en          = load_ready_o & load_dec.ok;

  // Response fields track the live response in RESP and hold it afterwards.
  assign instr_rdata_o = instr_rvalid_o ? (err_q ? ERR_RDATA : ram_q) : hold_rdata_q;
  assign instr_err_o   = instr_rvalid_o ? err_q : hold_err_q;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      idx_q        <= '0;
      err_q        <= 1'b0;
      hold_rdata_q <= 32'd0;
      hold_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (gnt) begin
        idx_q <= fetch_dec.idx;
        err_q <= ~fetch_dec.ok;
      end
      if (instr_rvalid_o) begin
        hold_rdata_q <= instr_rdata_o;
        hold_err_q   <= instr_err_o;
      end
    end
  end

  // NOTE: the array and its read register have no reset so they map onto plain SRAM.
  always_ff @(posedge clk) begin
    if (rd_en) ram_q <= mem[rd_idx];
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (load_be_i[b]) mem[load_dec.idx][8*b +: 8] <= load_wdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: three instances (0, 2 and 3 wait states)
// share one stimulus bus; each check targets the instance whose timing it exercises.
module tb_imem_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int unsigned WORDS = 16;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk, rst_n;
  logic        req, lwe;
  logic [31:0] addr, laddr, lwdata;
  logic [3:0]  lbe;

  logic        gnt [3];
  logic        rv  [3];
  logic        er  [3];
  logic        lr  [3];
  logic        bz  [3];
  logic [31:0] rd  [3];

  int n_cmp  = 0;
  int n_fail = 0;

  imem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt[0]), .instr_rvalid_o(rv[0]), .instr_rdata_o(rd[0]), .instr_err_o(er[0]),
    .load_we_i(lwe), .load_addr_i(laddr), .load_be_i(lbe), .load_wdata_i(lwdata),
    .load_ready_o(lr[0]), .busy_o(bz[0]));

  imem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .WAIT_STATES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt[1]), .instr_rvalid_o(rv[1]), .instr_rdata_o(rd[1]), .instr_err_o(er[1]),
    .load_we_i(lwe), .load_addr_i(laddr), .load_be_i(lbe), .load_wdata_i(lwdata),
    .load_ready_o(lr[1]), .busy_o(bz[1]));

  imem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt[2]), .instr_rvalid_o(rv[2]), .instr_rdata_o(rd[2]), .instr_err_o(er[2]),
    .load_we_i(lwe), .load_addr_i(laddr), .load_be_i(lbe), .load_wdata_i(lwdata),
    .load_ready_o(lr[2]), .busy_o(bz[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    lwe = 1'b0;
    repeat (n) next();
  endtask

  task automatic load(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    laddr  = a;
    lbe    = be;
    lwdata = d;
    lwe    = 1'b1;
    @(negedge clk);
    check("load_ready idle", 32'(lr[0]), 32'd1);
    next();
    lwe = 1'b0;
  endtask

  vec_t vec [8];

  initial begin
    rst_n = 1'b0; req = 1'b0; addr = '0; lwe = 1'b0; laddr = '0; lbe = '0; lwdata = '0;
    repeat (2) next();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset rvalid%0d", d), 32'(rv[d]), 32'd0);
      check($sformatf("reset err%0d", d),    32'(er[d]), 32'd0);
      check($sformatf("reset rdata%0d", d),  rd[d],      32'd0);
      check($sformatf("reset busy%0d", d),   32'(bz[d]), 32'd0);
    end
    next();
    rst_n = 1'b1;
    next();

    // Program image; the last three writes are misaligned / out of range and must be dropped.
    load(BASE + 32'h00, 4'hF, 32'hDEAD_BEEF);
    load(BASE + 32'h04, 4'hF, 32'h0000_0013);
    load(BASE + 32'h08, 4'hF, 32'h1122_3344);
    load(BASE + 32'h08, 4'b0101, 32'hAABB_CCDD);
    load(BASE + 32'h3C, 4'hF, 32'hCAFE_F00D);
    load(BASE + 32'h40, 4'hF, 32'h0BAD_0BAD);
    load(BASE + 32'h01, 4'hF, 32'h0BAD_0BAD);
    load(BASE - 32'h04, 4'hF, 32'h0BAD_0BAD);

    vec[0] = '{BASE + 32'h00,  32'hDEAD_BEEF, 1'b0};
    vec[1] = '{BASE + 32'h04,  32'h0000_0013, 1'b0};
    vec[2] = '{BASE + 32'h08,  32'h11BB_33DD, 1'b0};
    vec[3] = '{BASE + 32'h02,  NOP,           1'b1};
    vec[4] = '{BASE + 32'h40,  NOP,           1'b1};
    vec[5] = '{BASE - 32'h04,  NOP,           1'b1};
    vec[6] = '{32'h8000_1000,  NOP,           1'b1};
    vec[7] = '{BASE + 32'h3C,  32'hCAFE_F00D, 1'b0};

    // Back-to-back fetches on the zero-wait instance: one response per cycle.
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        req  = 1'b1;
        addr = vec[i].addr;
      end else begin
        req = 1'b0;
      end
      @(negedge clk);
      if (i < 8) check($sformatf("vec%0d gnt", i), 32'(gnt[0]), 32'd1);
      if (i > 0) begin
        check($sformatf("vec%0d rvalid", i-1), 32'(rv[0]), 32'd1);
        check($sformatf("vec%0d rdata", i-1),  rd[0],      vec[i-1].rdata);
        check($sformatf("vec%0d err", i-1),    32'(er[0]), 32'(vec[i-1].err));
      end
      next();
    end
    @(negedge clk);
    check("hold rvalid", 32'(rv[0]), 32'd0);
    check("hold rdata",  rd[0],      32'hCAFE_F00D);
    check("hold busy",   32'(bz[0]), 32'd0);
    idle(6);

    // Two wait states, request held high: grants at 0,3,6 and responses at 3,6.
    for (int i = 0; i < 7; i++) begin
      req  = 1'b1;
      addr = BASE + 32'h04;
      @(negedge clk);
      check($sformatf("ws cyc%0d gnt", i),    32'(gnt[1]), 32'((i % 3) == 0));
      check($sformatf("ws cyc%0d rvalid", i), 32'(rv[1]),  32'(i == 3 || i == 6));
      if (i == 3 || i == 6) check($sformatf("ws cyc%0d rdata", i), rd[1], 32'h0000_0013);
      if (i == 1) check("ws busy", 32'(bz[1]), 32'd1);
      next();
    end
    idle(6);

    // Misaligned fetch through the wait-state path.
    req  = 1'b1;
    addr = BASE + 32'h06;
    next();
    req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("ws err cyc%0d rvalid", k), 32'(rv[1]), 32'(k == 3));
      if (k == 3) begin
        check("ws err flag",  32'(er[1]), 32'd1);
        check("ws err rdata", rd[1],      NOP);
      end
      next();
    end
    idle(6);

    // Load and fetch collide: fetch wins, the write lands one cycle later.
    req    = 1'b1;
    addr   = BASE + 32'h08;
    lwe    = 1'b1;
    laddr  = BASE + 32'h08;
    lbe    = 4'hF;
    lwdata = 32'h5555_AAAA;
    @(negedge clk);
    check("conflict gnt",         32'(gnt[0]), 32'd1);
    check("conflict load_ready",  32'(lr[0]),  32'd0);
    next();
    req = 1'b0;
    @(negedge clk);
    check("conflict rvalid",      32'(rv[0]), 32'd1);
    check("conflict old rdata",   rd[0],      32'h11BB_33DD);
    check("deferred load_ready",  32'(lr[0]), 32'd1);
    next();
    lwe  = 1'b0;
    req  = 1'b1;
    addr = BASE + 32'h08;
    next();
    req = 1'b0;
    @(negedge clk);
    check("write-then-fetch rdata", rd[0], 32'h5555_AAAA);
    idle(6);

    // Reset one cycle after a grant on the three-wait instance aborts that fetch.
    req  = 1'b1;
    addr = BASE + 32'h00;
    @(negedge clk);
    check("abort gnt", 32'(gnt[2]), 32'd1);
    next();
    req   = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort rvalid", 32'(rv[2]), 32'd0);
    check("abort busy",   32'(bz[2]), 32'd0);
    check("abort rdata",  rd[2],      32'd0);
    next();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("post-reset cyc%0d rvalid", k), 32'(rv[2]), 32'd0);
      next();
    end
    req  = 1'b1;
    addr = BASE + 32'h00;
    @(negedge clk);
    check("post-reset gnt", 32'(gnt[2]), 32'd1);
    next();
    req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("post-reset fetch cyc%0d rvalid", k), 32'(rv[2]), 32'(k == 4));
      if (k == 4) begin
        check("post-reset fetch rdata", rd[2],      32'hDEAD_BEEF);
        check("post-reset fetch err",   32'(er[2]), 32'd0);
      end
      next();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
